// File: rtl/dice_results_pkg.sv
// Shared constants, state encoding and helpers for the result BRAM arbiter.
package dice_results_pkg;

    localparam int WORD_W           = 32;
    localparam int BYTE_W           = 8;
    localparam int BYTES_PER_WORD   = WORD_W / BYTE_W;
    localparam int ADDR_W           = 32;
    localparam int MAX_BURST        = 3;
    localparam int BURST_W          = MAX_BURST * WORD_W;
    localparam int LEN_W            = 2;
    localparam int HOLD_CYC_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WRITE,
        HOLD,
        ACK,
        DONE
    } state_e;

    // Index width that stays legal for a count of one or zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Word k of a latched burst; k never exceeds MAX_BURST-1 during a write.
    function automatic logic [WORD_W-1:0] word_of(input logic [BURST_W-1:0] d,
                                                  input logic [LEN_W-1:0]   k);
        case (k)
            2'd0:    return d[0*WORD_W +: WORD_W];
            2'd1:    return d[1*WORD_W +: WORD_W];
            default: return d[2*WORD_W +: WORD_W];
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the index after the last granted
// requester; the pointer only advances when the grant is taken (en).
module rr_arbiter
    import dice_results_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Pick the pending requester with the smallest rotational distance from ptr_q.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int d = 0; d < N_REQ; d++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!grant_valid && req[j] &&
                    ((j >= int'(ptr_q)) ? (j - int'(ptr_q)) : (j + N_REQ - int'(ptr_q))) == d) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(j);
                    grant[j]    = 1'b1;
                end
            end
        end
    end

    // Next search start is the requester after the one just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (en && grant_valid) begin
            ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Pointer register; requester 0 is searched first after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/result_bram_arbiter.sv
// Arbitrates result bursts from N_REQ requesters onto one BRAM write port.
// Each requester owns a REGION_WORDS-word region with its own wrapping write
// pointer. BRAM port signals and acks are registered, so they appear one cycle
// after the FSM state that produced them.
module result_bram_arbiter
    import dice_results_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int HOLD_CYC     = HOLD_CYC_DEFAULT,
    parameter int REGION_WORDS = 1024
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [LEN_W*N_REQ-1:0]    req_len,
    input  logic [BURST_W*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]          req_ack,
    input  logic                      finish,
    input  logic                      done_clr,
    output logic [ADDR_W-1:0]         addr,
    output logic [WORD_W-1:0]         din,
    output logic [BYTES_PER_WORD-1:0] we,
    output logic                      ea,
    output logic [N_REQ-1:0]          overflow,
    output logic                      save_done
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int RW_W  = idx_width(REGION_WORDS);
    localparam int HC_W  = idx_width(HOLD_CYC);

    localparam logic [RW_W-1:0] WPTR_LAST = RW_W'(REGION_WORDS - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            g_q, g_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic [BURST_W-1:0]          data_q, data_d;
    logic [LEN_W-1:0]            word_q, word_d;
    logic [HC_W-1:0]             hold_q, hold_d;
    logic [RW_W-1:0]             wptr_q [N_REQ];
    logic [RW_W-1:0]             wptr_d [N_REQ];
    logic [N_REQ-1:0]            overflow_q, overflow_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [WORD_W-1:0]           din_q, din_d;
    logic [BYTES_PER_WORD-1:0]   we_q, we_d;
    logic                        ea_q, ea_d;
    logic [N_REQ-1:0]            ack_q, ack_d;

    logic [N_REQ-1:0]            req_pend;
    logic [N_REQ-1:0]            arb_grant;
    logic [IDX_W-1:0]            arb_idx;
    logic                        arb_valid;
    logic                        arb_en;
    logic [LEN_W-1:0]            sel_len;
    logic [BURST_W-1:0]          sel_data;

    // A requester still sees its ack this cycle and may hold req_valid one
    // more cycle, so it is masked to avoid re-granting a finished burst.
    assign req_pend = req_valid & ~ack_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req_pend),
        .en          (arb_en),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Route the granted requester's length and data slice for latching.
    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (arb_grant[j]) begin
                sel_len  = req_len[LEN_W*j +: LEN_W];
                sel_data = req_data[BURST_W*j +: BURST_W];
            end
        end
    end

    // Burst sequencing FSM: next state, latched burst context and port drive.
    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        len_d      = len_q;
        data_d     = data_q;
        word_d     = word_q;
        hold_d     = hold_q;
        wptr_d     = wptr_q;
        overflow_d = overflow_q;
        addr_d     = '0;
        din_d      = '0;
        we_d       = '0;
        ea_d       = 1'b0;
        ack_d      = '0;
        arb_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (finish && !(|req_pend)) begin
                    state_d = DONE;
                end else if (|req_pend) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                if (arb_valid) begin
                    arb_en  = 1'b1;
                    g_d     = arb_idx;
                    len_d   = sel_len;
                    data_d  = sel_data;
                    word_d  = '0;
                    state_d = (sel_len == '0) ? ACK : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end

            WRITE: begin
                ea_d   = 1'b1;
                we_d   = '1;
                din_d  = word_of(data_q, word_q);
                addr_d = ADDR_W'((32'(g_q) * 32'(REGION_WORDS) + 32'(wptr_q[g_q]))
                                 * 32'(BYTES_PER_WORD));
                if (wptr_q[g_q] == WPTR_LAST) begin
                    wptr_d[g_q]     = '0;
                    overflow_d[g_q] = 1'b1;
                end else begin
                    wptr_d[g_q] = wptr_q[g_q] + RW_W'(1);
                end
                word_d = word_q + LEN_W'(1);
                hold_d = '0;
                if (HOLD_CYC == 0) begin
                    state_d = (word_d == len_q) ? ACK : WRITE;
                end else begin
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = (word_q == len_q) ? ACK : WRITE;
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end

            ACK: begin
                ack_d[g_q] = 1'b1;
                state_d    = IDLE;
            end

            DONE: begin
                if (done_clr) begin
                    state_d    = IDLE;
                    overflow_d = '0;
                    for (int i = 0; i < N_REQ; i++) begin
                        wptr_d[i] = '0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, burst context, write pointers and registered port outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            g_q        <= '0;
            len_q      <= '0;
            data_q     <= '0;
            word_q     <= '0;
            hold_q     <= '0;
            overflow_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            we_q       <= '0;
            ea_q       <= 1'b0;
            ack_q      <= '0;
            // NOTE: wptr is a handful of flops, not a RAM, so it is reset
            // like any other register; a real memory array would not be.
            for (int i = 0; i < N_REQ; i++) begin
                wptr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            len_q      <= len_d;
            data_q     <= data_d;
            word_q     <= word_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            we_q       <= we_d;
            ea_q       <= ea_d;
            ack_q      <= ack_d;
            wptr_q     <= wptr_d;
        end
    end

    assign addr      = addr_q;
    assign din       = din_q;
    assign we        = we_q;
    assign ea        = ea_q;
    assign req_ack   = ack_q;
    assign overflow  = overflow_q;
    assign save_done = (state_q == DONE);

endmodule

// File: tb/tb_result_bram_arbiter.sv
// Directed bench for result_bram_arbiter with hand-computed expectations.
// Cycle numbers count rising edges since the stimulus was applied; the
// request is accepted on edge 1 (grant), BRAM outputs are registered.
module tb_result_bram_arbiter;

    localparam int N_REQ        = 3;
    localparam int HOLD_CYC     = 3;
    localparam int REGION_WORDS = 1024;
    localparam int LW           = 2 * N_REQ;
    localparam int DW           = 96 * N_REQ;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b1;
    logic [N_REQ-1:0] req_valid = '0;
    logic [LW-1:0]    req_len   = '0;
    logic [DW-1:0]    req_data  = '0;
    logic [N_REQ-1:0] req_ack;
    logic             finish    = 1'b0;
    logic             done_clr  = 1'b0;
    logic [31:0]      addr;
    logic [31:0]      din;
    logic [3:0]       we;
    logic             ea;
    logic [N_REQ-1:0] overflow;
    logic             save_done;

    result_bram_arbiter #(
        .N_REQ        (N_REQ),
        .HOLD_CYC     (HOLD_CYC),
        .REGION_WORDS (REGION_WORDS)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .finish    (finish),
        .done_clr  (done_clr),
        .addr      (addr),
        .din       (din),
        .we        (we),
        .ea        (ea),
        .overflow  (overflow),
        .save_done (save_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  we;
    } wr_t;

    typedef struct {
        int cyc;
        int idx;
    } ack_t;

    wr_t              wr_log[$];
    ack_t             ack_log[$];
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    logic [N_REQ-1:0] drop_pending = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample after the edge, log writes/acks, drop acked requests
    // one cycle after their ack.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (drop_pending != '0) begin
            req_valid    = req_valid & ~drop_pending;
            drop_pending = '0;
        end
        if (ea) wr_log.push_back('{cyc, addr, din, we});
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ack[i]) begin
                ack_log.push_back('{cyc, i});
                drop_pending[i] = 1'b1;
            end
        end
    endtask

    task automatic set_req(input int idx, input int len,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        logic [LW-1:0] lmask;
        logic [DW-1:0] dmask;
        lmask     = LW'(3) << (2 * idx);
        dmask     = DW'({96{1'b1}}) << (96 * idx);
        req_len   = (req_len & ~lmask) | (LW'(len) << (2 * idx));
        req_data  = (req_data & ~dmask) | (DW'({w2, w1, w0}) << (96 * idx));
        req_valid = req_valid | (N_REQ'(1) << idx);
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k = 0;
        while (ack_log.size() < n && k < budget) begin
            step();
            k++;
        end
        if (ack_log.size() < n) check("ack_timeout", ack_log.size(), n);
    endtask

    // Full burst: request, wait for its ack, then one cycle for the drop.
    task automatic do_burst(input int idx, input int len,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        set_req(idx, len, w0, w1, w2);
        wait_acks(ack_log.size() + 1, 40);
        step();
    endtask

    task automatic expect_wr(input string tag, input int k, input logic [31:0] a,
                             input logic [31:0] d, input int c);
        if (wr_log.size() > k) begin
            check($sformatf("%s_w%0d_addr", tag, k), wr_log[k].addr, a);
            check($sformatf("%s_w%0d_din", tag, k), wr_log[k].din, d);
            check($sformatf("%s_w%0d_we", tag, k), 32'(wr_log[k].we), 32'hF);
            if (c >= 0) check($sformatf("%s_w%0d_cyc", tag, k), wr_log[k].cyc, c);
        end else begin
            check($sformatf("%s_w%0d_missing", tag, k), wr_log.size(), k + 1);
        end
    endtask

    task automatic expect_ack(input string tag, input int k, input int idx, input int c);
        if (ack_log.size() > k) begin
            check($sformatf("%s_a%0d_idx", tag, k), ack_log[k].idx, idx);
            if (c >= 0) check($sformatf("%s_a%0d_cyc", tag, k), ack_log[k].cyc, c);
        end else begin
            check($sformatf("%s_a%0d_missing", tag, k), ack_log.size(), k + 1);
        end
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        req_valid    = '0;
        req_len      = '0;
        req_data     = '0;
        finish       = 1'b0;
        done_clr     = 1'b0;
        drop_pending = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wr_log.delete();
        ack_log.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;

        // Reset values.
        #2 reset_n = 1'b0;
        #1;
        check("rst_addr", addr, 32'h0);
        check("rst_din", din, 32'h0);
        check("rst_we_ea", {27'd0, we, ea}, 32'h0);
        check("rst_ack", 32'(req_ack), 32'h0);
        check("rst_ovf_done", {28'd0, overflow, save_done}, 32'h0);
        apply_reset();

        // Single requester 0, len 3; data changed after grant must not leak.
        c0 = cyc;
        set_req(0, 3, 32'h11, 32'h22, 32'h33);
        step();
        step();
        set_req(0, 3, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
        wait_acks(1, 40);
        repeat (3) step();
        expect_wr("single", 0, 32'h0, 32'h11, c0 + 3);
        expect_wr("single", 1, 32'h4, 32'h22, c0 + 7);
        expect_wr("single", 2, 32'h8, 32'h33, c0 + 11);
        check("single_nwr", wr_log.size(), 3);
        expect_ack("single", 0, 0, c0 + 15);
        check("single_nack", ack_log.size(), 1);

        // Three simultaneous requests, len 1: round-robin 0,1,2.
        apply_reset();
        c0 = cyc;
        set_req(0, 1, 32'hA0, 32'h0, 32'h0);
        set_req(1, 1, 32'hB1, 32'h0, 32'h0);
        set_req(2, 1, 32'hC2, 32'h0, 32'h0);
        wait_acks(3, 80);
        repeat (3) step();
        expect_wr("rr", 0, 32'h0000, 32'hA0, c0 + 3);
        expect_wr("rr", 1, 32'h1000, 32'hB1, c0 + 10);
        expect_wr("rr", 2, 32'h2000, 32'hC2, c0 + 17);
        expect_ack("rr", 0, 0, c0 + 7);
        expect_ack("rr", 1, 1, c0 + 14);
        expect_ack("rr", 2, 2, c0 + 21);
        check("rr_nack", ack_log.size(), 3);

        // Zero-length burst: ack only, no BRAM write.
        apply_reset();
        c0 = cyc;
        set_req(1, 0, 32'h55, 32'h66, 32'h77);
        wait_acks(1, 20);
        repeat (3) step();
        expect_ack("len0", 0, 1, c0 + 3);
        check("len0_nwr", wr_log.size(), 0);

        // Requester 2 region wrap: 341 x 3 words, then 2 more (words 1024, 1025).
        apply_reset();
        for (int b = 0; b < 341; b++) begin
            do_burst(2, 3, 32'(3 * b), 32'(3 * b + 1), 32'(3 * b + 2));
        end
        check("wrap_nwr_1023", wr_log.size(), 1023);
        if (wr_log.size() == 1023) check("wrap_w1023_addr", wr_log[1022].addr, 32'h2FF8);
        check("wrap_ovf_before", 32'(overflow), 32'h0);
        wr_log.delete();
        do_burst(2, 2, 32'h0000_1024, 32'h0000_1025, 32'h0);
        expect_wr("wrap", 0, 32'h2FFC, 32'h0000_1024, -1);
        expect_wr("wrap", 1, 32'h2000, 32'h0000_1025, -1);
        check("wrap_ovf_after", 32'(overflow), 32'h4);

        // finish during a burst: burst completes, then DONE; done_clr clears.
        apply_reset();
        set_req(0, 2, 32'h51, 32'h52, 32'h0);
        repeat (3) step();
        finish = 1'b1;
        step();
        check("fin_busy_done", 32'(save_done), 32'h0);
        wait_acks(1, 40);
        expect_ack("fin", 0, 0, -1);
        step();
        check("fin_save_done", 32'(save_done), 32'h1);
        check("fin_nwr", wr_log.size(), 2);
        repeat (2) step();
        check("fin_done_hold", {27'd0, save_done, we, ea}, 32'h20);
        done_clr = 1'b1;
        finish   = 1'b0;
        step();
        done_clr = 1'b0;
        check("fin_clr", 32'(save_done), 32'h0);
        wr_log.delete();
        do_burst(0, 1, 32'h61, 32'h0, 32'h0);
        expect_wr("fin_after_clr", 0, 32'h0, 32'h61, -1);

        // Reset asserted while word 2 is on the port; re-request restarts at 0.
        apply_reset();
        set_req(0, 3, 32'h71, 32'h72, 32'h73);
        repeat (7) step();
        check("mid_w2_we", 32'(we), 32'hF);
        check("mid_w2_addr", addr, 32'h4);
        reset_n = 1'b0;
        #1;
        check("mid_rst_addr_din", addr | din, 32'h0);
        check("mid_rst_we_ea", {27'd0, we, ea}, 32'h0);
        check("mid_rst_ack", 32'(req_ack), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset_n      = 1'b1;
        drop_pending = '0;
        wr_log.delete();
        ack_log.delete();
        c0 = cyc;
        wait_acks(1, 40);
        repeat (3) step();
        expect_wr("rereq", 0, 32'h0, 32'h71, c0 + 3);
        expect_wr("rereq", 1, 32'h4, 32'h72, c0 + 7);
        expect_wr("rereq", 2, 32'h8, 32'h73, c0 + 11);
        expect_ack("rereq", 0, 0, c0 + 15);
        check("rereq_nack", ack_log.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/result_bram_arbiter.md
RESULT_BRAM_ARBITER -- requirements
Module: result_bram_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of result requesters.
REQ-002 SHALL have parameter HOLD_CYC, default 3, idle cycles after each BRAM word write.
REQ-003 SHALL have parameter REGION_WORDS, default 1024, words per requester address region (power of two).
REQ-004 SHALL have port clock  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester burst request, level, held until ack.
REQ-007 SHALL have port req_len  in  2*N_REQ  per-requester burst length in words (0..3).
REQ-008 SHALL have port req_data  in  96*N_REQ  per-requester words; word k at bits [32k+31:32k] of each 96-bit slice.
REQ-009 SHALL have port req_ack  out  N_REQ  one-cycle pulse when that requester's burst is fully written.
REQ-010 SHALL have port finish  in  1  level; no further results will be requested.
REQ-011 SHALL have port done_clr  in  1  pulse; clears done and returns to IDLE.
REQ-012 SHALL have ports addr  out  32, din  out  32, we  out  4, ea  out  1: BRAM port A byte address, data, byte write enables, enable.
REQ-013 SHALL have port overflow  out  N_REQ  sticky flag per requester, region wrapped.
REQ-014 SHALL have port save_done  out  1  all results written.

Function
REQ-015 SHALL implement states IDLE, ARB, WRITE, HOLD, ACK, DONE.
REQ-016 IDLE: if finish and no req_valid -> DONE; else if any req_valid -> ARB; else stay.
REQ-017 ARB SHALL grant round-robin starting at the index after the last granted requester; latch grant index, req_len and req_data in one cycle; go to WRITE (len>0) or ACK (len=0).
REQ-018 WRITE SHALL drive for exactly one cycle: ea=1, we=4'b1111, din=latched word k, addr=(g*REGION_WORDS + wptr[g])*4; then increment wptr[g], go to HOLD.
REQ-019 HOLD SHALL keep we=0, ea=0 for HOLD_CYC cycles, then WRITE for next word or ACK after last word.
REQ-020 ACK SHALL pulse req_ack[g] for one cycle and return to IDLE; requester drops req_valid no later than the cycle after ack.
REQ-021 wptr[g] SHALL wrap from REGION_WORDS-1 to 0 and set overflow[g] sticky on wrap.
REQ-022 A burst once granted SHALL complete regardless of finish; finish checked only in IDLE.
REQ-023 DONE SHALL hold save_done=1, we=0, ea=0 until done_clr, which returns to IDLE, clears save_done, wptr and overflow.
REQ-024 Burst latency: ARB to ack = 1 + len*(1+HOLD_CYC) + 1 cycles from grant.
REQ-025 req_data changes after grant SHALL NOT affect the burst in flight.
REQ-026 Non-granted requests SHALL remain pending with no loss.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, addr=0, din=0, we=0, ea=0, req_ack=0, save_done=0, overflow=0, all wptr=0, round-robin pointer to requester 0 next.
REQ-028 Reset mid-burst SHALL abandon the burst without ack; requester re-requests after reset.

Structure
REQ-029 State encoding, word/byte width constants and HOLD_CYC default SHALL live in shared package dice_results_pkg.
REQ-030 Round-robin grant logic SHALL be sub-module rr_arbiter (N_REQ requests in, one-hot grant + index out, pointer update on enable).

Verification
REQ-031 Single requester 0, len=3, data 0x11,0x22,0x33 -> writes addr 0x0,0x4,0x8 each followed by 3 idle cycles; ack at grant+14.
REQ-032 All three requesters valid simultaneously, len=1 -> grants order 0,1,2; writes at 0x0, 0x1000, 0x2000; three acks.
REQ-033 Requester 1 len=0 -> no BRAM write, ack 2 cycles after grant.
REQ-034 Requester 2 bursts totalling 1025 words -> word 1025 at 0x2000, overflow[2]=1.
REQ-035 finish asserted during requester 0 burst -> burst completes and acks, then save_done=1; done_clr -> save_done=0, IDLE.
REQ-036 reset_n low in HOLD of word 2 -> all outputs zero same cycle, no ack; re-request writes from addr 0x0.
